// File: rtl/boss_pkg.sv
// Shared types and geometry for the boss attack engine.
// Pattern entries carry up to MAX_PROJ projectile slots.
package boss_pkg;

  localparam int MAX_PROJ = 5;

  localparam logic [1:0] ATK_PROJ = 2'd0;
  localparam logic [1:0] ATK_BEAM = 2'd1;
  localparam logic [1:0] ATK_DIAG = 2'd2;

  localparam logic [9:0] BOSS_X = 10'd264;
  localparam logic [8:0] BOSS_Y = 9'd131;
  localparam logic [9:0] BOSS_W = 10'd400;
  localparam logic [8:0] BOSS_H = 9'd100;

  localparam logic [8:0] PROJ_Y = BOSS_Y + BOSS_H;
  localparam logic [9:0] PROJ_W = 10'd10;
  localparam logic [8:0] PROJ_H = 9'd15;
  localparam logic [9:0] BEAM_W = 10'd60;
  localparam logic [8:0] BEAM_H = 9'd280;
  localparam logic [9:0] DIAG_W = 10'd20;
  localparam logic [8:0] DIAG_H = 9'd20;

  // Rows are centred under the boss body.
  localparam logic [9:0] ROW_CX = BOSS_X + (BOSS_W >> 1);
  localparam logic [9:0] ROW_X0 = ROW_CX - (PROJ_W >> 1) - 10'd200;

  typedef struct packed {
    logic [MAX_PROJ-1:0]       valid_mask;
    logic [MAX_PROJ-1:0][9:0]  x;
    logic [MAX_PROJ-1:0][8:0]  y;
    logic [9:0]                w;
    logic [8:0]                h;
    logic [1:0]                atk_type;
    logic                      telegraph;
    logic                      ind_sel;
    logic                      no_fire;
    logic                      phase2_only;
  } pattern_t;

  function automatic logic [MAX_PROJ-1:0][8:0] row_y(input int n);
    row_y = '0;
    for (int k = 0; k < MAX_PROJ; k++)
      if (k < n) row_y[k] = PROJ_Y;
  endfunction

endpackage

// File: rtl/boss_pattern_rom.sv
// Combinational attack-pattern table.
// Entry 0 is warm-up; the loop runs over entries 1..7.
module boss_pattern_rom
  import boss_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx,
  output pattern_t         entry
);

  always_comb begin
    entry = '0;
    case (int'(idx))
      0: entry.no_fire = 1'b1;
      1, 3: begin
        entry.valid_mask = MAX_PROJ'(5'h1F);
        for (int k = 0; k < 5; k++)
          entry.x[k] = ROW_X0 + 10'(100 * k);
        entry.y        = row_y(5);
        entry.w        = PROJ_W;
        entry.h        = PROJ_H;
        entry.atk_type = ATK_PROJ;
      end
      2, 4: begin
        entry.valid_mask = MAX_PROJ'(4'hF);
        for (int k = 0; k < 4; k++)
          entry.x[k] = ROW_X0 + 10'd50 + 10'(100 * k);
        entry.y        = row_y(4);
        entry.w        = PROJ_W;
        entry.h        = PROJ_H;
        entry.atk_type = ATK_PROJ;
      end
      5: begin
        entry.valid_mask = MAX_PROJ'(2'b11);
        entry.x[0]       = BOSS_X - (BEAM_W >> 1);
        entry.x[1]       = BOSS_X + BOSS_W - (BEAM_W >> 1);
        entry.y          = row_y(2);
        entry.w          = BEAM_W;
        entry.h          = BEAM_H;
        entry.atk_type   = ATK_BEAM;
        entry.telegraph  = 1'b1;
        entry.ind_sel    = 1'b0;
      end
      6: begin
        entry.valid_mask = MAX_PROJ'(3'b111);
        entry.x[0]       = 10'd144;
        entry.x[1]       = 10'd434;
        entry.x[2]       = 10'd723;
        entry.y          = row_y(3);
        entry.w          = BEAM_W;
        entry.h          = BEAM_H;
        entry.atk_type   = ATK_BEAM;
        entry.telegraph  = 1'b1;
        entry.ind_sel    = 1'b1;
      end
      7: begin
        entry.valid_mask = MAX_PROJ'(2'b11);
        entry.x[0]       = 10'd244;
        entry.x[1]       = 10'd684;
        entry.y          = row_y(2);
        entry.w          = DIAG_W;
        entry.h          = DIAG_H;
        entry.atk_type   = ATK_DIAG;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/boss_attack_sequencer.sv
// Boss attack sequencer: steps the pattern table on each tick,
// telegraphs delayed attacks, tracks HP, enrage and death.
module boss_attack_sequencer
  import boss_pkg::*;
#(
  parameter int NUM_PROJ     = 5,
  parameter int NUM_PATTERNS = 8,
  parameter int LOOP_START   = 1,
  parameter int BOSS_HP      = 510,
  parameter int HIT_DMG      = 1,
  parameter int PHASE2_HP    = 255,
  parameter int DELAY_W      = 32
) (
  input  logic                  clk_master,
  input  logic                  rst,
  input  logic                  pulse_cycle_step,
  input  logic                  boss_hit,
  input  logic [DELAY_W-1:0]    telegraph_delay,
  output logic [NUM_PROJ*10-1:0] proj_x,
  output logic [NUM_PROJ*9-1:0] proj_y,
  output logic [NUM_PROJ-1:0]   proj_valid,
  output logic [9:0]            proj_w,
  output logic [8:0]            proj_h,
  output logic [1:0]            attack_type,
  output logic                  boss_shoot,
  output logic [1:0]            indicate,
  output logic [9:0]            boss_hp,
  output logic                  phase,
  output logic                  boss_dead
);

  localparam int IDX_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;

  typedef enum logic [1:0] {IDLE, TELEGRAPH, DEAD} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d, idx_nxt;
  logic [DELAY_W-1:0]        timer_q, timer_d;
  logic [DELAY_W-1:0]        dly_raw, dly_eff;
  logic [9:0]                hp_q, hp_d;
  logic                      phase_q, phase_d;
  logic                      dead_q, dead_d;
  logic                      shoot_q, shoot_d;
  logic [NUM_PROJ-1:0]       valid_q, valid_d;
  logic [NUM_PROJ-1:0][9:0]  x_q, x_d;
  logic [NUM_PROJ-1:0][8:0]  y_q, y_d;
  logic [9:0]                w_q, w_d;
  logic [8:0]                h_q, h_d;
  logic [1:0]                type_q, type_d;
  logic [1:0]                ind_q, ind_d;
  pattern_t                  ent;

  boss_pattern_rom #(.IDX_W(IDX_W)) u_rom (
    .idx   (idx_q),
    .entry (ent)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    hp_d    = hp_q;
    dead_d  = dead_q;
    shoot_d = 1'b0;
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    type_d  = type_q;
    ind_d   = ind_q;

    dly_raw = phase_q ? (telegraph_delay >> 1) : telegraph_delay;
    dly_eff = (dly_raw == '0) ? DELAY_W'(1) : dly_raw;
    idx_nxt = (idx_q == IDX_W'(NUM_PATTERNS - 1)) ?
              IDX_W'(LOOP_START) : idx_q + IDX_W'(1);

    if (boss_hit && hp_q != '0 && state_q != DEAD)
      hp_d = (hp_q <= 10'(HIT_DMG)) ? '0 : hp_q - 10'(HIT_DMG);
    phase_d = phase_q | (hp_q <= 10'(PHASE2_HP));

    // Death outranks any pending expiry or tick on the same edge.
    if (state_q != DEAD && hp_q == '0) begin
      state_d = DEAD;
      dead_d  = 1'b1;
      valid_d = '0;
      ind_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pulse_cycle_step) begin
            idx_d = idx_nxt;
            if (!(ent.phase2_only && !phase_q)) begin
              for (int k = 0; k < NUM_PROJ; k++) begin
                if (k < MAX_PROJ) begin
                  valid_d[k] = ent.valid_mask[k];
                  x_d[k]     = ent.x[k];
                  y_d[k]     = ent.y[k];
                end else begin
                  valid_d[k] = 1'b0;
                  x_d[k]     = '0;
                  y_d[k]     = '0;
                end
              end
              w_d    = ent.w;
              h_d    = ent.h;
              type_d = ent.atk_type;
              if (ent.no_fire) begin
                shoot_d = 1'b0;
              end else if (!ent.telegraph) begin
                shoot_d = 1'b1;
              end else begin
                ind_d              = '0;
                ind_d[ent.ind_sel] = 1'b1;
                timer_d            = dly_eff;
                state_d            = TELEGRAPH;
              end
            end
          end
        end
        TELEGRAPH: begin
          if (timer_q == DELAY_W'(1)) begin
            shoot_d = 1'b1;
            ind_d   = '0;
            state_d = IDLE;
          end else begin
            timer_d = timer_q - DELAY_W'(1);
          end
        end
        DEAD: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_master) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      hp_q    <= 10'(BOSS_HP);
      phase_q <= 1'b0;
      dead_q  <= 1'b0;
      shoot_q <= 1'b0;
      valid_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      type_q  <= '0;
      ind_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      hp_q    <= hp_d;
      phase_q <= phase_d;
      dead_q  <= dead_d;
      shoot_q <= shoot_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      type_q  <= type_d;
      ind_q   <= ind_d;
    end
  end

  assign proj_x      = x_q;
  assign proj_y      = y_q;
  assign proj_valid  = valid_q;
  assign proj_w      = w_q;
  assign proj_h      = h_q;
  assign attack_type = type_q;
  assign boss_shoot  = shoot_q;
  assign indicate    = ind_q;
  assign boss_hp     = hp_q;
  assign phase       = phase_q;
  assign boss_dead   = dead_q;

endmodule

// File: tb/tb_boss_attack_sequencer.sv
// Bench for boss_attack_sequencer: directed and random steps
// checked every cycle against a timestamp-based reference model.
module tb_boss_attack_sequencer;

  logic        clk_master = 1'b0;
  logic        rst = 1'b1;
  logic        pulse_cycle_step = 1'b0;
  logic        boss_hit = 1'b0;
  logic [31:0] telegraph_delay = 32'd10;
  logic [49:0] proj_x;
  logic [44:0] proj_y;
  logic [4:0]  proj_valid;
  logic [9:0]  proj_w;
  logic [8:0]  proj_h;
  logic [1:0]  attack_type;
  logic        boss_shoot;
  logic [1:0]  indicate;
  logic [9:0]  boss_hp;
  logic        phase;
  logic        boss_dead;

  boss_attack_sequencer dut (
    .clk_master       (clk_master),
    .rst              (rst),
    .pulse_cycle_step (pulse_cycle_step),
    .boss_hit         (boss_hit),
    .telegraph_delay  (telegraph_delay),
    .proj_x           (proj_x),
    .proj_y           (proj_y),
    .proj_valid       (proj_valid),
    .proj_w           (proj_w),
    .proj_h           (proj_h),
    .attack_type      (attack_type),
    .boss_shoot       (boss_shoot),
    .indicate         (indicate),
    .boss_hp          (boss_hp),
    .phase            (phase),
    .boss_dead        (boss_dead)
  );

  always #5 clk_master = ~clk_master;

  int checks = 0;
  int errors = 0;

  int t_mask [8] = '{0, 31, 15, 31, 15, 3, 7, 3};
  int t_x [8][5] = '{'{0, 0, 0, 0, 0},
                     '{259, 359, 459, 559, 659},
                     '{309, 409, 509, 609, 0},
                     '{259, 359, 459, 559, 659},
                     '{309, 409, 509, 609, 0},
                     '{234, 634, 0, 0, 0},
                     '{144, 434, 723, 0, 0},
                     '{244, 684, 0, 0, 0}};
  int t_w [8]    = '{0, 10, 10, 10, 10, 60, 60, 20};
  int t_h [8]    = '{0, 15, 15, 15, 15, 280, 280, 20};
  int t_type [8] = '{0, 0, 0, 0, 0, 1, 1, 2};
  int t_tel [8]  = '{0, 0, 0, 0, 0, 1, 1, 0};
  int t_sel [8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
  int t_nf [8]   = '{1, 0, 0, 0, 0, 0, 0, 0};

  int          m_idx, m_hp, m_shot_at, m_cyc;
  bit          m_phase, m_dead;
  logic [49:0] e_x;
  logic [44:0] e_y;
  logic [4:0]  e_valid;
  logic [9:0]  e_w;
  logic [8:0]  e_h;
  logic [1:0]  e_type, e_ind;
  logic        e_shoot;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("boss_shoot", 64'(boss_shoot), 64'(e_shoot));
    chk("indicate", 64'(indicate), 64'(e_ind));
    chk("proj_valid", 64'(proj_valid), 64'(e_valid));
    chk("proj_x", 64'(proj_x), 64'(e_x));
    chk("proj_y", 64'(proj_y), 64'(e_y));
    chk("proj_w", 64'(proj_w), 64'(e_w));
    chk("proj_h", 64'(proj_h), 64'(e_h));
    chk("attack_type", 64'(attack_type), 64'(e_type));
    chk("boss_hp", 64'(boss_hp), 64'(m_hp));
    chk("phase", 64'(phase), 64'(m_phase));
    chk("boss_dead", 64'(boss_dead), 64'(m_dead));
  endtask

  task automatic model_reset();
    m_idx = 0; m_hp = 510; m_shot_at = -1; m_cyc = 0;
    m_phase = 0; m_dead = 0;
    e_x = '0; e_y = '0; e_valid = '0; e_w = '0; e_h = '0;
    e_type = '0; e_ind = '0; e_shoot = 0;
  endtask

  // Telegraphs are tracked as an absolute fire cycle, not a countdown.
  task automatic model_edge(input bit p, input bit h);
    int  old_hp;
    bit  old_phase, was_dead;
    int  d;
    old_hp = m_hp; old_phase = m_phase; was_dead = m_dead;
    e_shoot = 0;
    if (m_dead) begin
    end else if (old_hp == 0) begin
      m_dead = 1; e_valid = '0; e_ind = '0; m_shot_at = -1;
    end else if (m_shot_at >= 0) begin
      if (m_cyc == m_shot_at) begin
        e_shoot = 1; e_ind = '0; m_shot_at = -1;
      end
    end else if (p) begin
      e_valid = 5'(t_mask[m_idx]);
      for (int k = 0; k < 5; k++) begin
        e_x[k*10 +: 10] = 10'(t_x[m_idx][k]);
        e_y[k*9 +: 9]   = e_valid[k] ? 9'd231 : 9'd0;
      end
      e_w = 10'(t_w[m_idx]); e_h = 9'(t_h[m_idx]);
      e_type = 2'(t_type[m_idx]);
      if (t_nf[m_idx] != 0) begin
      end else if (t_tel[m_idx] == 0) begin
        e_shoot = 1;
      end else begin
        e_ind = (t_sel[m_idx] != 0) ? 2'b10 : 2'b01;
        d = old_phase ? int'(telegraph_delay / 2) : int'(telegraph_delay);
        if (d < 1) d = 1;
        m_shot_at = m_cyc + d;
      end
      m_idx = (m_idx == 7) ? 1 : m_idx + 1;
    end
    if (!was_dead && h && old_hp > 0) m_hp = old_hp - 1;
    m_phase = old_phase || (old_hp <= 255);
    m_cyc++;
  endtask

  task automatic cyc(input bit p, input bit h);
    pulse_cycle_step = p;
    boss_hit = h;
    @(posedge clk_master);
    model_edge(p, h);
    #1;
    pulse_cycle_step = 0;
    boss_hit = 0;
    chk_all();
  endtask

  task automatic do_reset();
    rst = 1; pulse_cycle_step = 0; boss_hit = 0;
    @(posedge clk_master);
    model_reset();
    #1;
    rst = 0;
    chk_all();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && m_shot_at >= 0; i++) cyc(0, 0);
    if (m_shot_at >= 0) begin
      errors++;
      $error("FAIL wait_idle: telegraph never completed");
    end
  endtask

  task automatic goto_idx(input int target);
    for (int i = 0; i < 32 && m_idx != target; i++) begin
      cyc(1, 0);
      wait_idle();
    end
    if (m_idx != target) begin
      errors++;
      $error("FAIL goto_idx: index %0d never reached", target);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();
    chk("rst_hp", 64'(boss_hp), 64'd510);

    cyc(1, 0);
    chk("warmup_valid", 64'(proj_valid), 64'd0);
    chk("warmup_shoot", 64'(boss_shoot), 64'd0);
    cyc(0, 0);
    cyc(1, 0);
    chk("row5_shoot", 64'(boss_shoot), 64'd1);
    chk("row5_valid", 64'(proj_valid), 64'h1F);
    chk("row5_x0", 64'(proj_x[9:0]), 64'd259);
    chk("row5_y0", 64'(proj_y[8:0]), 64'd231);
    chk("row5_type", 64'(attack_type), 64'd0);
    cyc(0, 0);
    chk("shoot_one_cycle", 64'(boss_shoot), 64'd0);

    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(0, 3)) cyc(0, 0);
      cyc(1, 0);
    end

    telegraph_delay = 32'd10;
    cyc(1, 0);
    chk("tel5_ind", 64'(indicate), 64'd1);
    for (int i = 0; i < 9; i++) begin
      cyc(i == 3, 0);
      chk("tel5_wait_ind", 64'(indicate), 64'd1);
      chk("tel5_wait_shoot", 64'(boss_shoot), 64'd0);
    end
    cyc(0, 0);
    chk("tel5_shoot", 64'(boss_shoot), 64'd1);
    chk("tel5_w", 64'(proj_w), 64'd60);
    chk("tel5_h", 64'(proj_h), 64'd280);
    chk("tel5_ind_clr", 64'(indicate), 64'd0);
    cyc(1, 0);
    chk("dropped_pulse_idx6", 64'(indicate), 64'd2);
    wait_idle();

    cyc(1, 0);
    chk("diag_type", 64'(attack_type), 64'd2);
    cyc(0, 0);
    cyc(1, 0);
    chk("wrap_valid", 64'(proj_valid), 64'h1F);
    chk("wrap_x0", 64'(proj_x[9:0]), 64'd259);

    repeat (255) cyc(0, 1);
    cyc(0, 0);
    chk("enrage_hp", 64'(boss_hp), 64'd255);
    chk("enrage_phase", 64'(phase), 64'd1);

    goto_idx(6);
    telegraph_delay = 32'd10;
    cyc(1, 0);
    repeat (4) begin
      cyc(0, 0);
      chk("enr_wait", 64'(boss_shoot), 64'd0);
    end
    cyc(0, 0);
    chk("enr_shot5", 64'(boss_shoot), 64'd1);

    goto_idx(5);
    telegraph_delay = 32'd1;
    cyc(1, 0);
    chk("enr_d1_ind", 64'(indicate), 64'd1);
    cyc(0, 0);
    chk("enr_d1_shoot", 64'(boss_shoot), 64'd1);

    for (int i = 0; i < 300; i++) begin
      telegraph_delay = 32'($urandom_range(0, 9));
      cyc($urandom_range(0, 2) == 0,
          ($urandom_range(0, 7) == 0) && (m_hp > 40));
    end

    wait_idle();
    for (int i = 0; i < 400 && m_hp > 3; i++) cyc(0, 1);
    wait_idle();
    goto_idx(6);
    telegraph_delay = 32'd40;
    cyc(1, 0);
    chk("death_tel_ind", 64'(indicate), 64'd2);
    repeat (3) cyc(0, 1);
    chk("death_hp0", 64'(boss_hp), 64'd0);
    cyc(0, 0);
    chk("death_dead", 64'(boss_dead), 64'd1);
    chk("death_ind", 64'(indicate), 64'd0);
    chk("death_valid", 64'(proj_valid), 64'd0);
    for (int i = 0; i < 30; i++) begin
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      chk("dead_no_shoot", 64'(boss_shoot), 64'd0);
    end
    chk("dead_hp_stays", 64'(boss_hp), 64'd0);

    do_reset();
    goto_idx(5);
    telegraph_delay = 32'd10;
    cyc(1, 0);
    repeat (3) cyc(0, 0);
    do_reset();
    chk("midrst_hp", 64'(boss_hp), 64'd510);
    chk("midrst_ind", 64'(indicate), 64'd0);
    chk("midrst_valid", 64'(proj_valid), 64'd0);
    repeat (12) begin
      cyc(0, 0);
      chk("midrst_no_shoot", 64'(boss_shoot), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
